// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, instruction fields and FSM states for the ALU sequencer
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam int OP_MSB  = 10;
  localparam int OP_LSB  = 8;
  localparam int IMM_W   = 8;
  localparam int INSTR_W = OP_MSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_CAPTURE,
    ST_ADVANCE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_prog_mem.sv
// rtl/alu_prog_mem.sv - single-port program register file, synchronous write, asynchronous read
module alu_prog_mem
  import alu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [INSTR_W-1:0] wdata,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - runs a loaded ALU program against an 8-bit accumulator
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [10:0]       prog_data,
  input  logic [7:0]        init_val,
  input  logic              start,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_sel,
  input  logic [7:0]        alu_out,
  input  logic              alu_cout,
  output logic [7:0]        acc,
  output logic              carry,
  output logic              busy,
  output logic              done
);

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] mem_rdata;
  logic [ADDR_W-1:0]  mem_addr;
  logic [2:0]         fetch_op;
  logic [2:0]         ir_op;
  logic               last_pc;

  // One port serves both loading (IDLE) and fetching (pc) since they never overlap.
  assign mem_addr = (state == ST_IDLE) ? prog_addr : pc;
  assign fetch_op = mem_rdata[OP_MSB:OP_LSB];
  assign ir_op    = ir[OP_MSB:OP_LSB];
  assign last_pc  = (pc == ADDR_W'(DEPTH - 1));

  alu_prog_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_prog_mem (
    .clk   (clk),
    .we    (prog_we && (state == ST_IDLE)),
    .addr  (mem_addr),
    .wdata (prog_data),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (start) state_n = ST_FETCH;
      ST_FETCH: begin
        if (fetch_op == OP_HALT)     state_n = ST_DONE;
        else if (fetch_op == OP_NOP) state_n = ST_ADVANCE;
        else                         state_n = ST_ISSUE;
      end
      ST_ISSUE:   state_n = ST_CAPTURE;
      ST_CAPTURE: state_n = ST_ADVANCE;
      ST_ADVANCE: state_n = last_pc ? ST_DONE : ST_FETCH;
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      carry   <= 1'b0;
      pc      <= '0;
      ir      <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= OP_NOP;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= init_val;
            carry <= 1'b0;
            pc    <= '0;
          end
        end
        ST_FETCH: ir <= mem_rdata;
        ST_ISSUE: begin
          alu_a   <= acc;
          alu_b   <= ir[IMM_W-1:0];
          alu_sel <= ir_op;
        end
        ST_CAPTURE: begin
          acc <= alu_out;
          // Only ADD defines the carry; SUB clears it, logic ops and INC leave it alone.
          if (ir_op == OP_ADD)      carry <= alu_cout;
          else if (ir_op == OP_SUB) carry <= 1'b0;
        end
        ST_ADVANCE: if (!last_pc) pc <= pc + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with a behavioural ALU and program model
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [10:0] prog_data = '0;
  logic [7:0]  init_val = '0;
  logic        start = 1'b0;
  logic [7:0]  alu_a, alu_b, alu_out, acc;
  logic [2:0]  alu_sel;
  logic        alu_cout, carry, busy, done;

  int tests = 0;
  int fails = 0;

  logic [10:0] shadow [16];
  logic [7:0]  acc_log [512];
  logic [2:0]  sel_log [512];
  int          done_cyc;
  int          done_cnt;
  int          end_cyc;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .init_val(init_val), .start(start), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout), .acc(acc), .carry(carry), .busy(busy), .done(done)
  );

  always_comb begin
    alu_out = alu_a;
    case (alu_sel)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a + 8'd1;
      3'b010: alu_out = alu_a - alu_b;
      3'b011: alu_out = alu_a ^ alu_b;
      3'b100: alu_out = alu_a | alu_b;
      3'b101: alu_out = alu_a & alu_b;
      default: alu_out = alu_a;
    endcase
  end
  assign alu_cout = (9'(alu_a) + 9'(alu_b)) > 9'd255;

  function automatic logic [10:0] ins(input logic [2:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  // Reference: walk the shadow program, applying each op and summing per-instruction cycle costs.
  task automatic model(input logic [7:0] init, output logic [7:0] a, output logic c, output int cyc);
    logic [2:0] op;
    logic [7:0] imm;
    logic [8:0] sum;
    a = init; c = 1'b0; cyc = 0;
    for (int p = 0; p < 16; p++) begin
      op = shadow[p][10:8];
      imm = shadow[p][7:0];
      if (op == 3'b110) begin cyc += 2; return; end
      if (op == 3'b111) begin cyc += 2; continue; end
      cyc += 4;
      case (op)
        3'b000: begin sum = {1'b0, a} + {1'b0, imm}; a = sum[7:0]; c = sum[8]; end
        3'b001: a = a + 8'd1;
        3'b010: begin a = a - imm; c = 1'b0; end
        3'b011: a = a ^ imm;
        3'b100: a = a | imm;
        default: a = a & imm;
      endcase
    end
    cyc += 1;
  endtask

  task automatic load_word(input int addr, input logic [10:0] w);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr[3:0]; prog_data = w;
    @(posedge clk); #1;
    prog_we = 1'b0;
    shadow[addr] = w;
  endtask

  // mode 0: undisturbed; 1: prog_we+start pulse at cycle 'at'; 2: rst asserted at cycle 'at'.
  task automatic run(input logic [7:0] init, input int mode, input int at);
    int cyc;
    done_cyc = -1; done_cnt = 0; end_cyc = -1;
    @(negedge clk);
    init_val = init; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      acc_log[cyc] = acc;
      sel_log[cyc] = alu_sel;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!busy) begin end_cyc = cyc; break; end
      if (mode == 1 && cyc == at) begin
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = ins(3'b110, 8'h00); start = 1'b1;
      end
      if (mode == 2 && cyc == at) rst = 1'b1;
      @(posedge clk); #1;
      prog_we = 1'b0; start = 1'b0;
      cyc++;
      if (mode == 2 && cyc == at + 1) begin rst = 1'b0; end_cyc = cyc; break; end
    end
    tests++;
    if (end_cyc < 0) begin
      fails++;
      $display("FAIL run_timeout: busy still %0b after %0d cycles, required idle", busy, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({acc, carry, busy, done, alu_a, alu_b, alu_sel} !== {8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'b111}) begin
      fails++;
      $display("FAIL reset_values: acc=%h carry=%b busy=%b done=%b a=%h b=%h sel=%b, required 00 0 0 0 00 00 111",
               acc, carry, busy, done, alu_a, alu_b, alu_sel);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    load_word(0, ins(3'b000, 8'h05));
    load_word(1, ins(3'b010, 8'h03));
    load_word(2, ins(3'b110, 8'h00));
    run(8'h10, 0, 0);
    tests++;
    if (acc !== 8'h12 || carry !== 1'b0) begin
      fails++; $display("FAIL add_sub_result: acc=%h carry=%b, required 12 0", acc, carry);
    end
    tests++;
    if (done_cyc !== 10 || done_cnt !== 1) begin
      fails++; $display("FAIL add_sub_timing: done at %0d count %0d, required 10 1", done_cyc, done_cnt);
    end
    tests++;
    if (end_cyc !== 11) begin
      fails++; $display("FAIL add_sub_busy_drop: idle at %0d, required 11", end_cyc);
    end
  endtask

  task automatic test_carry();
    load_word(0, ins(3'b000, 8'h01));
    load_word(1, ins(3'b110, 8'h00));
    run(8'hFF, 0, 0);
    tests++;
    if (acc !== 8'h00 || carry !== 1'b1) begin
      fails++; $display("FAIL add_carry: acc=%h carry=%b, required 00 1", acc, carry);
    end
    load_word(0, ins(3'b010, 8'h01));
    run(8'h00, 0, 0);
    tests++;
    if (acc !== 8'hFF || carry !== 1'b0) begin
      fails++; $display("FAIL sub_wrap: acc=%h carry=%b, required ff 0", acc, carry);
    end
  endtask

  task automatic test_logic();
    logic [7:0] exp_acc [4];
    logic [2:0] exp_sel [4];
    exp_acc = '{8'h5A, 8'h5F, 8'h1C, 8'h1D};
    exp_sel = '{3'b011, 3'b100, 3'b101, 3'b001};
    load_word(0, ins(3'b011, 8'hFF));
    load_word(1, ins(3'b100, 8'h0F));
    load_word(2, ins(3'b101, 8'h3C));
    load_word(3, ins(3'b001, 8'h99));
    load_word(4, ins(3'b110, 8'h00));
    run(8'hA5, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (acc_log[4*k+4] !== exp_acc[k]) begin
        fails++; $display("FAIL logic_acc[%0d]: acc=%h, required %h", k, acc_log[4*k+4], exp_acc[k]);
      end
      tests++;
      if (sel_log[4*k+3] !== exp_sel[k]) begin
        fails++; $display("FAIL logic_sel[%0d]: sel=%b, required %b", k, sel_log[4*k+3], exp_sel[k]);
      end
    end
  endtask

  task automatic test_full_inc();
    for (int i = 0; i < 16; i++) load_word(i, ins(3'b001, 8'($urandom)));
    run(8'h00, 0, 0);
    tests++;
    if (acc !== 8'h10 || done_cyc !== 65 || done_cnt !== 1) begin
      fails++; $display("FAIL full_inc: acc=%h done at %0d count %0d, required 10 65 1", acc, done_cyc, done_cnt);
    end
  endtask

  task automatic test_ignored_inputs();
    logic [7:0] ea; logic ec; int ecyc;
    load_word(0, ins(3'b000, 8'h05));
    load_word(1, ins(3'b010, 8'h03));
    load_word(2, ins(3'b110, 8'h00));
    model(8'h10, ea, ec, ecyc);
    run(8'h10, 1, 3);
    tests++;
    if (acc !== ea || carry !== ec || done_cyc !== ecyc || done_cnt !== 1) begin
      fails++; $display("FAIL ignore_busy_inputs: acc=%h carry=%b done at %0d count %0d, required %h %b %0d 1",
                        acc, carry, done_cyc, done_cnt, ea, ec, ecyc);
    end
    run(8'h10, 0, 0);
    tests++;
    if (acc !== ea || done_cyc !== ecyc) begin
      fails++; $display("FAIL ignore_prog_intact: acc=%h done at %0d, required %h %0d", acc, done_cyc, ea, ecyc);
    end
  endtask

  task automatic test_rst_mid();
    run(8'h10, 2, 7);
    tests++;
    if ({acc, carry, busy, alu_sel} !== {8'h00, 1'b0, 1'b0, 3'b111} || done_cnt !== 0) begin
      fails++; $display("FAIL rst_mid: acc=%h carry=%b busy=%b sel=%b dones=%0d, required 00 0 0 111 0",
                        acc, carry, busy, alu_sel, done_cnt);
    end
    run(8'h10, 0, 0);
    tests++;
    if (acc !== 8'h12 || carry !== 1'b0 || done_cyc !== 10) begin
      fails++; $display("FAIL rst_rerun: acc=%h carry=%b done at %0d, required 12 0 10", acc, carry, done_cyc);
    end
  endtask

  task automatic test_random();
    logic [7:0] ea, init; logic ec; int ecyc;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 16; i++) begin
        logic [2:0] op;
        op = 3'($urandom_range(0, 7));
        if (op == 3'b110 && $urandom_range(0, 2) != 0) op = 3'b000;
        load_word(i, ins(op, 8'($urandom)));
      end
      init = 8'($urandom);
      model(init, ea, ec, ecyc);
      run(init, 0, 0);
      tests++;
      if (acc !== ea || carry !== ec || done_cyc !== ecyc || done_cnt !== 1) begin
        fails++; $display("FAIL random[%0d]: acc=%h carry=%b done at %0d count %0d, required %h %b %0d 1",
                          n, acc, carry, done_cyc, done_cnt, ea, ec, ecyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_carry();
    test_logic();
    test_full_inc();
    test_ignored_inputs();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 8-bit ALU operand/opcode interface.
- Holds a small loadable program of ALU instructions and executes it against a running 8-bit accumulator.
- For each instruction: drives alu_a/alu_b/alu_sel, captures alu_out/alu_cout, updates acc and carry flag.
- Sits between a host/testbench loader and one combinational ALU instance.

Parameters:
- DEPTH, 16, number of program-memory entries (power of two).
- ADDR_W, 4, program counter width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- prog_we  input  1  program write strobe; honoured only in IDLE.
- prog_addr  input  ADDR_W  program write address.
- prog_data  input  11  instruction: [10:8] op, [7:0] imm.
- init_val  input  8  accumulator seed, sampled on accepted start.
- start  input  1  begin execution at address 0; honoured only in IDLE.
- alu_a  output  8  ALU operand A (= acc).
- alu_b  output  8  ALU operand B (= current imm).
- alu_sel  output  3  ALU opcode.
- alu_out  input  8  ALU result.
- alu_cout  input  1  ALU carry (carry of A+B, independent of sel).
- acc  output  8  accumulator.
- carry  output  1  carry flag.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when execution ends.

Behaviour:
- Opcodes (ALU encoding): 000 ADD, 001 INC, 010 SUB, 011 XOR, 100 OR, 101 AND; 110 HALT; 111 NOP.
- Reset values: acc=0, carry=0, busy=0, done=0, alu_a=0, alu_b=0, alu_sel=3'b111, pc=0, state IDLE. Program memory is not cleared.
- States:
  - IDLE: prog_we writes mem[prog_addr]. Accepted start loads acc=init_val, clears carry, sets pc=0, goes to FETCH. prog_we and start in the same cycle: write first, then start; execution sees the new word.
  - FETCH: register mem[pc] into ir. HALT goes to DONE. NOP goes to ADVANCE. Any other op goes to ISSUE.
  - ISSUE: registered alu_a=acc, alu_b=ir.imm, alu_sel=ir.op. Go to CAPTURE.
  - CAPTURE: acc<=alu_out. carry<=alu_cout only for ADD; cleared for SUB; unchanged for other ops. Go to ADVANCE.
  - ADVANCE: if pc==DEPTH-1, go to DONE (no wrap); else pc<=pc+1 and go to FETCH.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Timing: ALU op costs 4 cycles (FETCH, ISSUE, CAPTURE, ADVANCE). NOP costs 2. HALT: FETCH then DONE.
- Arithmetic: all 8-bit, modulo 256. INC ignores imm (ALU computes A+1).
- Ignored inputs:
  - prog_we while busy: no write.
  - start while busy: no restart.
- Interface hold: ALU outputs hold their last values outside ISSUE; consumers sample alu_out only in CAPTURE.
- rst in any state: everything returns to reset values on the next edge, including mid-program and in DONE; done does not pulse.

Decomposition:
- Shared package alu_pkg:
  - op localparams OP_ADD..OP_NOP (3'b000..3'b111).
  - state encoding (IDLE, FETCH, ISSUE, CAPTURE, ADVANCE, DONE).
  - instruction field positions (OP_MSB=10, OP_LSB=8, IMM_W=8).
- Natural sub-module: alu_prog_mem, DEPTH x 11 single-port register file with synchronous write and asynchronous read.
- Top-level FSM instantiates alu_prog_mem; the ALU itself stays outside.

Test Plan:
- Load {ADD 0x05, SUB 0x03, HALT}; init_val=0x10; start; bench-modelled ALU -> acc=0x12, carry=0, done one pulse, busy low next cycle, total 10 cycles start-to-done.
- Load {ADD 0x01}; init_val=0xFF -> acc=0x00, carry=1. Then {SUB 0x01}; init_val=0x00 -> acc=0xFF, carry=0.
- Load {XOR 0xFF, OR 0x0F, AND 0x3C, INC 0x99}; init_val=0xA5 -> acc after each: 0x5A, 0x5F, 0x1C, 0x1D; alu_sel seen in ISSUE: 011, 100, 101, 001.
- Fill all 16 entries with INC, no HALT; init_val=0 -> acc=0x10, done after pc=15, pc does not wrap, no 17th op.
- During execution pulse prog_we (addr 0, data HALT) and start -> program unchanged, no restart, result identical to undisturbed run.
- Assert rst in CAPTURE of the 2nd instruction -> next cycle acc=0, carry=0, busy=0, alu_sel=111, no done pulse; a fresh start runs the program normally.
